// File: rtl/id_alu_issue.sv
// RV32I decode/issue stage: decodes ALU-class instructions, selects operands from
// the register file, PC or immediates, and registers them for the execute-stage ALU.
module id_alu_issue #(
  parameter bit SUPPORT_JUMP = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        flush_i,
  output logic [31:0] op1_o,
  output logic [31:0] op2_o,
  output logic [3:0]  alu_opcode_o,
  output logic [4:0]  rd_addr_o,
  output logic        rd_we_o,
  output logic        illegal_o,
  output logic        valid_o,
  input  logic        ready_i
);

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluXor  = 4'd2;
  localparam logic [3:0] AluOr   = 4'd3;
  localparam logic [3:0] AluAnd  = 4'd4;
  localparam logic [3:0] AluSll  = 4'd5;
  localparam logic [3:0] AluSrl  = 4'd6;
  localparam logic [3:0] AluSra  = 4'd7;
  localparam logic [3:0] AluSlt  = 4'd8;
  localparam logic [3:0] AluSltu = 4'd9;

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;
  localparam logic [6:0] OpcJal   = 7'b1101111;
  localparam logic [6:0] OpcJalr  = 7'b1100111;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] shamt_r;
  logic [31:0] shamt_i;

  logic [31:0] dec_op1, dec_op2;
  logic [3:0]  dec_opc;
  logic        dec_legal;
  logic        transfer;

  logic [31:0] op1_q, op2_q;
  logic [3:0]  opc_q;
  logic [4:0]  rd_q;
  logic        we_q, illegal_q, valid_q;

  assign opcode  = instr_i[6:0];
  assign funct3  = instr_i[14:12];
  assign funct7  = instr_i[31:25];
  assign imm_i   = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_u   = {instr_i[31:12], 12'b0};
  // The ALU shifts by the whole op2, so shift amounts are reduced to 5 bits here.
  assign shamt_r = {27'b0, rs2_data_i[4:0]};
  assign shamt_i = {27'b0, instr_i[24:20]};

  assign rs1_addr_o    = instr_i[19:15];
  assign rs2_addr_o    = instr_i[24:20];
  assign instr_ready_o = !valid_q || ready_i;
  assign transfer      = instr_valid_i && instr_ready_o;

  always_comb begin
    dec_op1   = 32'b0;
    dec_op2   = 32'b0;
    dec_opc   = AluAdd;
    dec_legal = 1'b0;
    // opcode[1:0] must be 2'b11 in every match below, so compressed encodings fall to default.
    case (opcode)
      OpcOp: begin
        dec_op1   = rs1_data_i;
        dec_op2   = rs2_data_i;
        dec_legal = 1'b1;
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: dec_opc = AluAdd;
          {7'b0100000, 3'b000}: dec_opc = AluSub;
          {7'b0000000, 3'b001}: begin dec_opc = AluSll; dec_op2 = shamt_r; end
          {7'b0000000, 3'b010}: dec_opc = AluSlt;
          {7'b0000000, 3'b011}: dec_opc = AluSltu;
          {7'b0000000, 3'b100}: dec_opc = AluXor;
          {7'b0000000, 3'b101}: begin dec_opc = AluSrl; dec_op2 = shamt_r; end
          {7'b0100000, 3'b101}: begin dec_opc = AluSra; dec_op2 = shamt_r; end
          {7'b0000000, 3'b110}: dec_opc = AluOr;
          {7'b0000000, 3'b111}: dec_opc = AluAnd;
          default:              dec_legal = 1'b0;
        endcase
      end
      OpcOpImm: begin
        dec_op1   = rs1_data_i;
        dec_op2   = imm_i;
        dec_legal = 1'b1;
        case (funct3)
          3'b000: dec_opc = AluAdd;
          3'b010: dec_opc = AluSlt;
          3'b011: dec_opc = AluSltu;
          3'b100: dec_opc = AluXor;
          3'b110: dec_opc = AluOr;
          3'b111: dec_opc = AluAnd;
          3'b001: begin
            dec_opc   = AluSll;
            dec_op2   = shamt_i;
            dec_legal = (funct7 == 7'b0000000);
          end
          default: begin
            dec_op2 = shamt_i;
            if (funct7 == 7'b0000000)      dec_opc = AluSrl;
            else if (funct7 == 7'b0100000) dec_opc = AluSra;
            else                           dec_legal = 1'b0;
          end
        endcase
      end
      OpcLui: begin
        dec_op2   = imm_u;
        dec_legal = 1'b1;
      end
      OpcAuipc: begin
        dec_op1   = pc_i;
        dec_op2   = imm_u;
        dec_legal = 1'b1;
      end
      OpcJal, OpcJalr: begin
        dec_op1   = pc_i;
        dec_op2   = 32'd4;
        dec_legal = SUPPORT_JUMP && ((opcode == OpcJal) || (funct3 == 3'b000));
      end
      default: dec_legal = 1'b0;
    endcase
    if (!dec_legal) begin
      dec_op1 = 32'b0;
      dec_op2 = 32'b0;
      dec_opc = AluAdd;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= 1'b0;
      op1_q     <= 32'b0;
      op2_q     <= 32'b0;
      opc_q     <= AluAdd;
      rd_q      <= 5'b0;
      we_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (transfer) begin
      valid_q   <= 1'b1;
      op1_q     <= dec_op1;
      op2_q     <= dec_op2;
      opc_q     <= dec_opc;
      rd_q      <= instr_i[11:7];
      we_q      <= dec_legal && (instr_i[11:7] != 5'd0);
      illegal_q <= !dec_legal;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign op1_o        = op1_q;
  assign op2_o        = op2_q;
  assign alu_opcode_o = opc_q;
  assign rd_addr_o    = rd_q;
  assign rd_we_o      = we_q;
  assign illegal_o    = illegal_q;
  assign valid_o      = valid_q;

endmodule

// File: tb/tb_id_alu_issue.sv
// Directed bench for id_alu_issue: hand-computed decode results, backpressure, flush
// and asynchronous reset behaviour.
module tb_id_alu_issue;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] instr_i, pc_i, rs1_data_i, rs2_data_i;
  logic        instr_valid_i, flush_i, ready_i;
  logic        instr_ready_o;
  logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic [31:0] op1_o, op2_o;
  logic [3:0]  alu_opcode_o;
  logic        rd_we_o, illegal_o, valid_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  id_alu_issue #(.SUPPORT_JUMP(1'b1)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .instr_i       (instr_i),
    .pc_i          (pc_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .rs1_addr_o    (rs1_addr_o),
    .rs2_addr_o    (rs2_addr_o),
    .rs1_data_i    (rs1_data_i),
    .rs2_data_i    (rs2_data_i),
    .flush_i       (flush_i),
    .op1_o         (op1_o),
    .op2_o         (op2_o),
    .alu_opcode_o  (alu_opcode_o),
    .rd_addr_o     (rd_addr_o),
    .rd_we_o       (rd_we_o),
    .illegal_o     (illegal_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] e_op1, input logic [31:0] e_op2,
                           input logic [3:0] e_opc, input logic [4:0] e_rd, input logic e_we,
                           input logic e_ill, input logic e_valid);
    check({tag, ".op1"}, op1_o, e_op1);
    check({tag, ".op2"}, op2_o, e_op2);
    check({tag, ".opc"}, {28'b0, alu_opcode_o}, {28'b0, e_opc});
    check({tag, ".rd"}, {27'b0, rd_addr_o}, {27'b0, e_rd});
    check({tag, ".we"}, {31'b0, rd_we_o}, {31'b0, e_we});
    check({tag, ".ill"}, {31'b0, illegal_o}, {31'b0, e_ill});
    check({tag, ".valid"}, {31'b0, valid_o}, {31'b0, e_valid});
  endtask

  initial begin
    rst_ni = 1'b0; instr_i = 32'b0; pc_i = 32'h100; instr_valid_i = 1'b0;
    rs1_data_i = 32'b0; rs2_data_i = 32'b0; flush_i = 1'b0; ready_i = 1'b1;
    step(); step();
    check_out("reset", 32'h0, 32'h0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst_ni = 1'b1;
    #1;
    check("reset.ready", {31'b0, instr_ready_o}, 32'd1);

    // ADD x3,x1,x2
    instr_i = 32'h002081B3; rs1_data_i = 32'd5; rs2_data_i = 32'd7; instr_valid_i = 1'b1;
    #1;
    check("add.rs1_addr", {27'b0, rs1_addr_o}, 32'd1);
    check("add.rs2_addr", {27'b0, rs2_addr_o}, 32'd2);
    step();
    check_out("add", 32'd5, 32'd7, 4'd0, 5'd3, 1'b1, 1'b0, 1'b1);

    instr_i = 32'h402081B3;
    step();
    check_out("sub", 32'd5, 32'd7, 4'd1, 5'd3, 1'b1, 1'b0, 1'b1);

    instr_i = 32'h002091B3; rs2_data_i = 32'h00000123;
    step();
    check_out("sll", 32'd5, 32'd3, 4'd5, 5'd3, 1'b1, 1'b0, 1'b1);

    instr_i = 32'h4030D313;
    step();
    check_out("srai", 32'd5, 32'd3, 4'd7, 5'd6, 1'b1, 1'b0, 1'b1);

    instr_i = 32'hFFF00293; rs1_data_i = 32'd0;
    step();
    check_out("addi", 32'd0, 32'hFFFFFFFF, 4'd0, 5'd5, 1'b1, 1'b0, 1'b1);

    instr_i = 32'h123453B7; rs1_data_i = 32'hDEADBEEF;
    step();
    check_out("lui", 32'd0, 32'h12345000, 4'd0, 5'd7, 1'b1, 1'b0, 1'b1);

    // Backpressure: LUI result must stay put while a new ADD waits.
    ready_i = 1'b0; instr_i = 32'h002081B3; rs1_data_i = 32'd5; rs2_data_i = 32'd7;
    #1;
    check("bp.ready0", {31'b0, instr_ready_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp.ready", {31'b0, instr_ready_o}, 32'd0);
      check_out("bp", 32'd0, 32'h12345000, 4'd0, 5'd7, 1'b1, 1'b0, 1'b1);
    end

    flush_i = 1'b1;
    step();
    check("flush.valid", {31'b0, valid_o}, 32'd0);
    flush_i = 1'b0; instr_valid_i = 1'b0; ready_i = 1'b1;
    #1;
    check("flush.ready", {31'b0, instr_ready_o}, 32'd1);
    step();
    check("flush.dropped", {31'b0, valid_o}, 32'd0);

    instr_i = 32'h0000000B; instr_valid_i = 1'b1;
    step();
    check_out("illegal", 32'd0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b1);

    instr_i = 32'h002081B1;
    step();
    check_out("compressed", 32'd0, 32'd0, 4'd0, 5'd3, 1'b0, 1'b1, 1'b1);

    instr_i = 32'h00208033;
    step();
    check_out("add_x0", 32'd5, 32'd7, 4'd0, 5'd0, 1'b0, 1'b0, 1'b1);

    // JAL x1,4 at pc 0x100 -> link value pc+4 via ADD
    instr_i = 32'h004000EF; pc_i = 32'h00000100;
    step();
    check_out("jal", 32'h100, 32'd4, 4'd0, 5'd1, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset while holding an instruction.
    instr_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    check_out("async_rst", 32'h0, 32'h0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst_ni = 1'b1;
    #1;
    check("async_rst.ready", {31'b0, instr_ready_o}, 32'd1);
    step();
    check("async_rst.idle", {31'b0, valid_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
